// File: rtl/imem_loader_pkg.sv
// Shared definitions for the instruction-memory loader: loader state encoding and
// stream/word geometry constants.
package imem_loader_pkg;

  localparam int unsigned LEN_W          = 16;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned INSTR_W        = 32;
  localparam int unsigned BYTE_CNT_W     = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    StIdle,
    StLenLo,
    StLenHi,
    StData,
    StCheck,
    StDone,
    StErr
  } loader_state_e;

endpackage

// File: rtl/imem_loader_byte_packer.sv
// Little-endian byte-to-word packer. Each accepted byte shifts in from the top, so after
// four bytes the first one sits in bits [7:0]. The completed word and its valid pulse are
// registered, giving a one-cycle latency from the last byte to the write strobe.
module imem_loader_byte_packer
  import imem_loader_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               clr,
  input  logic               take,
  input  logic [7:0]         data,
  output logic [INSTR_W-1:0] word,
  output logic               word_valid,
  output logic               word_complete
);

  logic [BYTE_CNT_W-1:0] cnt_q;
  logic [INSTR_W-9:0]    shift_q;
  logic [INSTR_W-1:0]    shift_next;
  logic [INSTR_W-1:0]    word_q;
  logic                  valid_q;

  assign shift_next    = {data, shift_q};
  // High when the byte taken this cycle is the last one of a word.
  assign word_complete = take && (cnt_q == BYTE_CNT_W'(BYTES_PER_WORD - 1));

  // Byte counter, shift register and registered word output.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q   <= '0;
      shift_q <= '0;
      word_q  <= '0;
      valid_q <= 1'b0;
    end else begin
      valid_q <= word_complete;
      if (clr) begin
        cnt_q <= '0;
      end else if (take) begin
        cnt_q   <= cnt_q + BYTE_CNT_W'(1);
        shift_q <= shift_next[INSTR_W-1:8];
      end
      // Word output only changes when a new word completes, so it holds between writes.
      if (word_complete) begin
        word_q <= shift_next;
      end
    end
  end

  assign word       = word_q;
  assign word_valid = valid_q;

endmodule

// File: rtl/imem_loader.sv
// Byte-stream program loader: parses LEN_LO, LEN_HI, then N little-endian 32-bit words and
// writes them to the imem write port from word 0, holding the CPU until a valid image is in.
// Optional trailing XOR checksum byte is enabled by defining IMEM_LOADER_CHECKSUM_EN.
module imem_loader
  import imem_loader_pkg::*;
#(
  parameter int unsigned ADDR_W = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start,
  input  logic               in_valid,
  input  logic [7:0]         in_data,
  output logic               in_ready,
  output logic               imem_we,
  output logic [ADDR_W-1:0]  imem_addr,
  output logic [INSTR_W-1:0] imem_wdata,
  output logic               cpu_hold,
  output logic               done,
  output logic               error,
  output logic [LEN_W-1:0]   words_loaded
);

  localparam int unsigned CAPACITY = 32'd1 << ADDR_W;

`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam loader_state_e POST_DATA = StCheck;
`else
  localparam loader_state_e POST_DATA = StDone;
`endif

  loader_state_e      state_q, state_d;
  logic               in_ready_q, in_ready_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic [LEN_W-1:0]   words_q, words_d;
  logic [ADDR_W-1:0]  addr_q, addr_d;

  logic               fire;
  logic               restart;
  logic               take;
  logic               last_accept;
  logic [LEN_W-1:0]   len_in;
  logic [INSTR_W-1:0] pk_word;
  logic               pk_valid;
  logic               pk_complete;

  assign fire    = in_valid && in_ready_q;
  assign restart = start && (state_q inside {StIdle, StDone, StErr});
  assign take    = fire && (state_q == StData);
  assign len_in  = {in_data, len_q[7:0]};
  // Final byte of the image: in_ready must drop right away so nothing extra is taken.
  assign last_accept = pk_complete && ((words_q + LEN_W'(1)) == len_q);

  imem_loader_byte_packer u_packer (
    .clk           (clk),
    .rst           (rst),
    .clr           (restart),
    .take          (take),
    .data          (in_data),
    .word          (pk_word),
    .word_valid    (pk_valid),
    .word_complete (pk_complete)
  );

`ifdef IMEM_LOADER_CHECKSUM_EN
  logic [7:0] csum_q, csum_d;

  // Running XOR over the length and data bytes; the check byte itself is excluded.
  always_comb begin
    csum_d = csum_q;
    if (restart) begin
      csum_d = '0;
    end else if (fire && (state_q != StCheck)) begin
      csum_d = csum_q ^ in_data;
    end
  end

  // Checksum register.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      csum_q <= '0;
    end else begin
      csum_q <= csum_d;
    end
  end
`endif

  // Next-state, length capture, word counting and registered in_ready.
  always_comb begin
    state_d = state_q;
    len_d   = len_q;
    words_d = words_q;
    addr_d  = addr_q;

    unique case (state_q)
      StIdle, StDone, StErr: begin
        if (start) begin
          state_d = StLenLo;
          len_d   = '0;
          words_d = '0;
        end
      end
      StLenLo: begin
        if (fire) begin
          len_d   = {8'h00, in_data};
          state_d = StLenHi;
        end
      end
      StLenHi: begin
        if (fire) begin
          len_d = len_in;
          if (len_in == '0) begin
            state_d = POST_DATA;
          end else if (32'(len_in) > CAPACITY) begin
            state_d = StErr;
          end else begin
            state_d = StData;
          end
        end
      end
      StData: begin
        // Address and count advance together with the registered write strobe.
        if (pk_complete) begin
          addr_d  = words_q[ADDR_W-1:0];
          words_d = words_q + LEN_W'(1);
        end
        // Leave once the final word's write strobe is on the port.
        if (pk_valid && (words_q == len_q)) begin
          state_d = POST_DATA;
        end
      end
`ifdef IMEM_LOADER_CHECKSUM_EN
      StCheck: begin
        if (fire) begin
          state_d = (in_data == csum_q) ? StDone : StErr;
        end
      end
`endif
      default: begin
        state_d = StIdle;
      end
    endcase

    in_ready_d = (state_d inside {StLenLo, StLenHi, StData, StCheck}) && !last_accept;
  end

  // State and datapath registers.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= StIdle;
      in_ready_q <= 1'b0;
      len_q      <= '0;
      words_q    <= '0;
      addr_q     <= '0;
    end else begin
      state_q    <= state_d;
      in_ready_q <= in_ready_d;
      len_q      <= len_d;
      words_q    <= words_d;
      addr_q     <= addr_d;
    end
  end

  assign in_ready     = in_ready_q;
  assign imem_we      = pk_valid;
  assign imem_addr    = addr_q;
  assign imem_wdata   = pk_word;
  assign cpu_hold     = (state_q != StDone);
  assign done         = (state_q == StDone);
  assign error        = (state_q == StErr);
  assign words_loaded = words_q;

endmodule

// File: tb/tb_imem_loader.sv
// Self-checking bench for imem_loader: randomized byte streams compared against a
// stream-level reference model (expected words rebuilt from the byte list).
module tb_imem_loader;

  localparam int ADDR_W = 8;
  localparam int CAP    = 1 << ADDR_W;
`ifdef IMEM_LOADER_CHECKSUM_EN
  localparam bit CSUM_EN = 1'b1;
`else
  localparam bit CSUM_EN = 1'b0;
`endif

  logic              clk = 1'b0;
  logic              rst;
  logic              start;
  logic              in_valid;
  logic [7:0]        in_data;
  logic              in_ready;
  logic              imem_we;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_wdata;
  logic              cpu_hold;
  logic              done;
  logic              error;
  logic [15:0]       words_loaded;

  int          n_checks = 0;
  int          n_errors = 0;
  int          we_cnt   = 0;
  logic [31:0] cap [CAP];
  logic [7:0]  fixed_img [$];

  imem_loader #(.ADDR_W(ADDR_W)) dut (
    .clk          (clk),
    .rst          (rst),
    .start        (start),
    .in_valid     (in_valid),
    .in_data      (in_data),
    .in_ready     (in_ready),
    .imem_we      (imem_we),
    .imem_addr    (imem_addr),
    .imem_wdata   (imem_wdata),
    .cpu_hold     (cpu_hold),
    .done         (done),
    .error        (error),
    .words_loaded (words_loaded)
  );

  always #5 clk = ~clk;

  // Capture of what the DUT writes into imem.
  always @(posedge clk) begin
    if (imem_we) begin
      cap[imem_addr] <= imem_wdata;
      we_cnt         <= we_cnt + 1;
    end
  end

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // Called at a negedge; returns at the negedge after the byte was accepted.
  task automatic send_byte(input logic [7:0] b, input bit gaps);
    bit taken = 1'b0;
    for (int t = 0; t < 64 && !taken; t++) begin
      if (gaps && ($urandom_range(0, 1) == 0)) begin
        in_valid = 1'b0;
        in_data  = 8'($urandom);
      end else begin
        in_valid = 1'b1;
        in_data  = b;
      end
      taken = in_valid && in_ready;
      @(negedge clk);
    end
    if (!taken) check_eq("accept_timeout", 32'(taken), 1);
  endtask

  task automatic pulse_start();
    in_valid = 1'b0;
    start    = 1'b1;
    @(negedge clk);
    start = 1'b0;
  endtask

  // One complete load; the expected outcome is derived from the stream rules.
  task automatic run_load(input int n, input bit gaps, input bit use_fixed, input bit poke_start,
                          input bit bad_csum);
    logic [7:0]  bytes [$];
    logic [7:0]  csum;
    logic [31:0] exp_w;
    int          base;
    int          t;
    bit          ok;
    bytes = {};
    bytes.push_back(n[7:0]);
    bytes.push_back(n[15:8]);
    if (n <= CAP) begin
      for (int i = 0; i < n * 4; i++) begin
        bytes.push_back(use_fixed ? fixed_img[i] : 8'($urandom));
      end
    end
    csum = 8'h00;
    foreach (bytes[i]) csum = csum ^ bytes[i];
    base = we_cnt;

    pulse_start();
    check_eq("start_clr_done", 32'(done), 0);
    check_eq("start_clr_err", 32'(error), 0);
    send_byte(bytes[0], gaps);
    send_byte(bytes[1], gaps);

    if (n > CAP) begin
      check_eq("len_err_flag", 32'(error), 1);
      check_eq("len_err_hold", 32'(cpu_hold), 1);
      check_eq("len_err_rdy", 32'(in_ready), 0);
      in_valid = 1'b1;
      repeat (4) @(negedge clk);
      in_valid = 1'b0;
      check_eq("len_err_nowrite", 32'(we_cnt - base), 0);
      check_eq("len_err_sticky", 32'(error), 1);
      return;
    end

    for (int k = 2; k < bytes.size(); k++) begin
      if (poke_start && k == 3) pulse_start();
      send_byte(bytes[k], gaps);
    end
    if (n > 0) check_eq("rdy_drop", 32'(in_ready), 0);
    if (CSUM_EN) send_byte(bad_csum ? (csum ^ 8'h5a) : csum, gaps);

    // Keep offering junk: nothing more may be taken.
    in_valid = 1'b1;
    in_data  = 8'($urandom);
    t = 0;
    while (!(done || error) && t < 50) begin
      @(negedge clk);
      t++;
    end
    in_valid = 1'b0;
    check_eq("end_timeout", 32'(done || error), 1);

    ok = !(CSUM_EN && bad_csum);
    check_eq("done", 32'(done), 32'(ok));
    check_eq("error", 32'(error), 32'(!ok));
    check_eq("cpu_hold", 32'(cpu_hold), 32'(!ok));
    check_eq("words_loaded", 32'(words_loaded), n);
    check_eq("we_pulses", 32'(we_cnt - base), n);
    for (int i = 0; i < n; i++) begin
      exp_w = {bytes[4*i+5], bytes[4*i+4], bytes[4*i+3], bytes[4*i+2]};
      check_eq($sformatf("imem[%0d]", i), cap[i], exp_w);
    end
  endtask

  initial begin
    logic [7:0]  bytes [$];
    logic [31:0] w0;
    int          base;
    int          n;

    rst      = 1'b1;
    start    = 1'b0;
    in_valid = 1'b0;
    in_data  = 8'h00;
    repeat (2) @(negedge clk);
    check_eq("rst_in_ready", 32'(in_ready), 0);
    check_eq("rst_we", 32'(imem_we), 0);
    check_eq("rst_addr", 32'(imem_addr), 0);
    check_eq("rst_wdata", imem_wdata, 0);
    check_eq("rst_hold", 32'(cpu_hold), 1);
    check_eq("rst_done", 32'(done), 0);
    check_eq("rst_error", 32'(error), 0);
    check_eq("rst_words", 32'(words_loaded), 0);
    rst = 1'b0;

    // in_valid held without start: nothing accepted.
    base     = we_cnt;
    in_valid = 1'b1;
    in_data  = 8'h02;
    repeat (8) @(negedge clk);
    check_eq("nostart_rdy", 32'(in_ready), 0);
    check_eq("nostart_words", 32'(words_loaded), 0);
    check_eq("nostart_we", 32'(we_cnt - base), 0);
    in_valid = 1'b0;

    // Known two-instruction image, without and with gaps.
    fixed_img = {8'h13, 8'h00, 8'h00, 8'h00, 8'h93, 8'h00, 8'h10, 8'h00};
    run_load(2, 1'b0, 1'b1, 1'b0, 1'b0);
    check_eq("fixed_w0", cap[0], 32'h0000_0013);
    check_eq("fixed_w1", cap[1], 32'h0010_0093);
    run_load(2, 1'b1, 1'b1, 1'b0, 1'b0);

    // DONE ignores further traffic.
    base     = we_cnt;
    in_valid = 1'b1;
    repeat (5) @(negedge clk);
    in_valid = 1'b0;
    check_eq("done_sticky", 32'(done), 1);
    check_eq("done_nowrite", 32'(we_cnt - base), 0);

    // Oversize length.
    run_load(32'h0101, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load(int'($urandom_range(CAP + 1, 65535)), 1'b1, 1'b0, 1'b0, 1'b0);

    // Reset after the 5th data byte: only word 0 written.
    bytes = {8'h02, 8'h00};
    for (int i = 0; i < 8; i++) bytes.push_back(8'($urandom));
    w0   = {bytes[5], bytes[4], bytes[3], bytes[2]};
    base = we_cnt;
    pulse_start();
    for (int k = 0; k < 7; k++) send_byte(bytes[k], 1'b0);
    in_valid = 1'b0;
    rst      = 1'b1;
    #1;
    check_eq("midrst_hold", 32'(cpu_hold), 1);
    check_eq("midrst_done", 32'(done), 0);
    check_eq("midrst_rdy", 32'(in_ready), 0);
    @(negedge clk);
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_eq("midrst_we", 32'(we_cnt - base), 1);
    check_eq("midrst_w0", cap[0], w0);
    check_eq("midrst_words", 32'(words_loaded), 0);
    run_load(3, 1'b1, 1'b0, 1'b0, 1'b0);

    // Empty image, start ignored mid-DATA, full capacity.
    run_load(0, 1'b0, 1'b0, 1'b0, 1'b0);
    run_load(4, 1'b0, 1'b0, 1'b1, 1'b0);
    run_load(CAP, 1'b0, 1'b0, 1'b0, 1'b0);
    check_eq("cap_last_addr", 32'(imem_addr), CAP - 1);

    if (CSUM_EN) run_load(3, 1'b1, 1'b0, 1'b0, 1'b1);

    // Random loads.
    for (int r = 0; r < 8; r++) begin
      n = ($urandom_range(0, 7) == 0) ? int'($urandom_range(CAP + 1, 65535))
                                      : int'($urandom_range(1, 20));
      run_load(n, 1'($urandom_range(0, 1)), 1'b0, 1'($urandom_range(0, 1)), 1'b0);
    end

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
